uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter: configurable data width, parity, stop bits and baud, with a TX FIFO.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 56 +++++
 rtl/uart_tx_cfg.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX path (and the planned RX path).
//   uart_state_t  frame state encoding (IDLE/START/DATA/PAR/STOP)
//   PARITY_*      parity mode codes used by the PARITY parameter
//   uart_div()    clock cycles per bit period
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int uart_div(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic synchronous FIFO with first-word-fall-through read.
//   clk, reset      clock, asynchronous active-high reset (flushes the FIFO)
//   i_push          write i_wr_data (ignored while full)
//   i_wr_data       write data
//   i_pop           drop the head entry (ignored while empty)
//   o_rd_data       head entry, valid while !o_empty
//   o_full/o_empty  occupancy flags
//   o_level         number of stored entries, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with TX FIFO.
// Sends queued words back to back, LSB first, with optional parity and 1/2 stop bits.
//   clk, reset   system clock, asynchronous active-high reset (aborts frame, flushes FIFO)
//   in_data      word to transmit (DATA_BITS wide)
//   in_valid     in_data valid; accepted on a rising edge when in_ready
//   in_ready     FIFO not full
//   tx           registered serial line, idle high
//   tx_busy      frame in flight or FIFO non-empty
//   fifo_level   FIFO occupancy
//
// state | meaning
// IDLE  | line idle, waiting for FIFO data
// START | start bit (low), one bit period
// DATA  | DATA_BITS data bits, LSB first
// PAR   | parity bit, only when PARITY != none
// STOP  | STOP_BITS stop bits (high); pops the next word directly on exit
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int               DIV        = uart_div(CLOCK_FREQ, BAUD_RATE);
    localparam int               CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic             PAR_ODD    = (PARITY == PARITY_ODD);

    uart_state_t            r_state;
    uart_state_t            w_state_next;
    logic [CNT_W-1:0]       r_baud_cnt;
    logic [3:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_busy;

    logic                   w_tick;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_tx_next;
    logic                   w_busy;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_fifo_data;

    assign w_push   = in_valid && !w_full;
    assign in_ready = !w_full;
    assign tx       = r_tx;
    assign tx_busy  = r_busy;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_wr_data (in_data),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    // Terminal count of the bit-period down-counter marks the last cycle of a bit.
    assign w_tick = (r_baud_cnt == '0);
    assign w_busy = (r_state != IDLE) || !w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_tick) w_state_next = DATA;
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_tick && r_bit_idx == LAST_DATA)
                    w_state_next = HAS_PARITY ? PAR : STOP;
            end
            PAR: begin
                w_tx_next = r_par;
                if (w_tick) w_state_next = STOP;
            end
            STOP: begin
                if (w_tick && r_bit_idx == LAST_STOP) begin
                    // Chain straight into the next start bit to keep the line gap-free.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // tx and tx_busy are registered from the FSM, so both lag the state by one
    // cycle; every bit still lasts exactly DIV cycles on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= CNT_RELOAD;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= w_busy;

            if (r_state == IDLE || w_tick) r_baud_cnt <= CNT_RELOAD;
            else                           r_baud_cnt <= r_baud_cnt - CNT_W'(1);

            // Bit index counts bits within the current state; cleared on every state change.
            if (w_tick) begin
                if (w_state_next != r_state) r_bit_idx <= '0;
                else                         r_bit_idx <= r_bit_idx + 4'd1;
            end

            // Parity is captured once with the word so the PAR bit cannot see a shifted value.
            if (w_pop) begin
                r_shift <= w_fifo_data;
                r_par   <= (^w_fifo_data) ^ PAR_ODD;
            end else if (r_state == DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

    localparam int DIV = 10;
    localparam int DBK  [4] = '{8, 8, 8, 5};
    localparam int PARK [4] = '{0, 2, 1, 0};
    localparam int STK  [4] = '{1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din8 [3];
    logic [4:0] din5;
    logic       vld  [4];
    logic       rdy  [4];
    logic       w_tx [4];
    logic       busy [4];
    logic [4:0] lvl  [4];
    longint     cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         k;
        logic [7:0] data;
        logic       par_bit;
        logic       start_ok;
        logic       stop_ok;
        longint     start_cyc;
    } frame_t;

    frame_t rxq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_cfg #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .clk(clk), .reset(rst), .in_data(din8[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .tx(w_tx[0]), .tx_busy(busy[0]), .fifo_level(lvl[0]));

    uart_tx_cfg #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
        .clk(clk), .reset(rst), .in_data(din8[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .tx(w_tx[1]), .tx_busy(busy[1]), .fifo_level(lvl[1]));

    uart_tx_cfg #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_8o2 (
        .clk(clk), .reset(rst), .in_data(din8[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .tx(w_tx[2]), .tx_busy(busy[2]), .fifo_level(lvl[2]));

    uart_tx_cfg #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_5n1 (
        .clk(clk), .reset(rst), .in_data(din5), .in_valid(vld[3]), .in_ready(rdy[3]),
        .tx(w_tx[3]), .tx_busy(busy[3]), .fifo_level(lvl[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: parity bit from the count of ones, frame length from bit counts.
    function automatic logic model_par(input logic [7:0] d, input int db, input int par);
        int ones = 0;
        for (int i = 0; i < db; i++) ones += int'(d[i]);
        if (par == 2) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    function automatic longint frame_len(input int k);
        return longint'(DIV * (1 + DBK[k] + ((PARK[k] != 0) ? 1 : 0) + STK[k]));
    endfunction

    // Line receiver: detects the start bit and samples each bit at mid-period.
    task automatic rx_loop(input int k);
        frame_t f;
        forever begin
            @(negedge clk);
            if (w_tx[k] === 1'b0) begin
                f.k         = k;
                f.data      = '0;
                f.par_bit   = 1'b0;
                f.stop_ok   = 1'b1;
                f.start_cyc = cyc;
                repeat (DIV / 2) @(negedge clk);
                f.start_ok = (w_tx[k] === 1'b0);
                for (int i = 0; i < DBK[k]; i++) begin
                    repeat (DIV) @(negedge clk);
                    f.data[i] = w_tx[k];
                end
                if (PARK[k] != 0) begin
                    repeat (DIV) @(negedge clk);
                    f.par_bit = w_tx[k];
                end
                for (int i = 0; i < STK[k]; i++) begin
                    repeat (DIV) @(negedge clk);
                    if (w_tx[k] !== 1'b1) f.stop_ok = 1'b0;
                end
                rxq.push_back(f);
            end
        end
    endtask

    initial rx_loop(0);
    initial rx_loop(1);
    initial rx_loop(2);
    initial rx_loop(3);

    task automatic push(input int k, input logic [7:0] d, output longint t_acc);
        int st = 0;
        if (k == 3) din5 = d[4:0];
        else        din8[k] = d;
        vld[k] = 1'b1;
        while (rdy[k] !== 1'b1 && st < 1000) begin
            @(negedge clk);
            st++;
        end
        if (st >= 1000) check("push_timeout", 64'(st), 64'(0));
        @(negedge clk);
        t_acc  = cyc;
        vld[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, output longint t_fall);
        int n = 0;
        @(negedge clk);
        while (busy[k] !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("busy_timeout", 64'(busy[k]), 64'(0));
        t_fall = cyc;
    endtask

    task automatic check_frame(input int k, input logic [7:0] d, output longint s0);
        frame_t     f;
        int         n = 0;
        logic [7:0] m;
        while (rxq.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rxq.size() == 0) begin
            f = '{k: -1, data: '0, par_bit: 1'b0, start_ok: 1'b0, stop_ok: 1'b0, start_cyc: 0};
        end else begin
            f = rxq.pop_front();
        end
        m = d & 8'((1 << DBK[k]) - 1);
        check($sformatf("rx_inst[%0d]", k), 64'(f.k), 64'(k));
        check($sformatf("rx_data[%0d]", k), 64'(f.data), 64'(m));
        check($sformatf("rx_start[%0d]", k), 64'(f.start_ok), 64'(1));
        check($sformatf("rx_stop[%0d]", k), 64'(f.stop_ok), 64'(1));
        if (PARK[k] != 0)
            check($sformatf("rx_parity[%0d]", k), 64'(f.par_bit), 64'(model_par(d, DBK[k], PARK[k])));
        s0 = f.start_cyc;
    endtask

    initial begin
        longint     t, tf, s0, s_prev, s_first;
        logic [7:0] d;
        logic [7:0] burst [3];
        logic [7:0] q[$];
        int         st;
        logic       ok;

        rst  = 1'b1;
        din5 = '0;
        for (int k = 0; k < 4; k++) vld[k] = 1'b0;
        for (int k = 0; k < 3; k++) din8[k] = '0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_tx[%0d]", k), 64'(w_tx[k]), 64'(1));
            check($sformatf("rst_busy[%0d]", k), 64'(busy[k]), 64'(0));
            check($sformatf("rst_ready[%0d]", k), 64'(rdy[k]), 64'(1));
            check($sformatf("rst_level[%0d]", k), 64'(lvl[k]), 64'(0));
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames: 8N1 0xA5, 8E1 0xA5, 8O2 0xA5, 5N1 0x1F.
        for (int k = 0; k < 4; k++) begin
            d = (k == 3) ? 8'h1F : 8'hA5;
            push(k, d, t);
            wait_idle(k, tf);
            check_frame(k, d, s0);
            check($sformatf("latency[%0d]", k), 64'(s0 - t), 64'(2));
            check($sformatf("busy_len[%0d]", k), 64'(tf - s0), 64'(frame_len(k)));
        end

        // Back-to-back bursts: fixed 01/02/03 on 8N1, then random on every configuration.
        for (int r = 0; r < 5; r++) begin
            int k;
            k = (r == 0) ? 0 : r - 1;
            for (int i = 0; i < 3; i++)
                burst[i] = (r == 0) ? 8'(i + 1) : 8'($urandom);
            for (int i = 0; i < 3; i++) push(k, burst[i], t);
            wait_idle(k, tf);
            s_prev  = 0;
            s_first = 0;
            for (int i = 0; i < 3; i++) begin
                check_frame(k, burst[i], s0);
                if (i == 0) s_first = s0;
                else check($sformatf("spacing[%0d]", k), 64'(s0 - s_prev), 64'(frame_len(k)));
                s_prev = s0;
            end
            check($sformatf("burst_busy[%0d]", k), 64'(tf - s_first), 64'(3 * frame_len(k)));
        end

        // FIFO fill: one word drains immediately, so the 18th beat is the one held back.
        for (int i = 0; i < 18; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            din8[0] = d;
            vld[0]  = 1'b1;
            st = 0;
            while (rdy[0] !== 1'b1 && st < 1000) begin
                check("full_level", 64'(lvl[0]), 64'(16));
                @(negedge clk);
                st++;
            end
            check($sformatf("held_beat[%0d]", i), 64'(st > 0), 64'(i == 17));
            @(negedge clk);
            check("level_max", 64'(lvl[0] <= 5'd16), 64'(1));
            check("ready_vs_level", 64'(rdy[0]), 64'(lvl[0] != 5'd16));
        end
        vld[0] = 1'b0;
        check("level_refilled", 64'(lvl[0]), 64'(16));
        wait_idle(0, tf);
        s_prev = 0;
        for (int i = 0; i < 18; i++) begin
            check_frame(0, q[i], s0);
            if (i > 0) check("fill_spacing", 64'(s0 - s_prev), 64'(100));
            s_prev = s0;
        end

        // Reset 35 cycles into a frame with two more words queued.
        push(0, 8'h5A, t);
        push(0, 8'($urandom), t);
        push(0, 8'($urandom), t);
        st = 0;
        while (w_tx[0] !== 1'b0 && st < 100) begin
            @(negedge clk);
            st++;
        end
        check("pre_reset_start", 64'(w_tx[0]), 64'(0));
        repeat (35) @(negedge clk);
        check("pre_reset_low", 64'(w_tx[0]), 64'(0));
        rst = 1'b1;
        #1;
        check("abort_tx", 64'(w_tx[0]), 64'(1));
        check("abort_level", 64'(lvl[0]), 64'(0));
        check("abort_busy", 64'(busy[0]), 64'(0));
        check("abort_ready", 64'(rdy[0]), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (w_tx[0] !== 1'b1 || busy[0] !== 1'b0 || lvl[0] !== 5'd0) ok = 1'b0;
        end
        check("post_reset_idle", 64'(ok), 64'(1));
        rxq.delete();
        push(0, 8'hC3, t);
        wait_idle(0, tf);
        check_frame(0, 8'hC3, s0);
        check("post_reset_latency", 64'(s0 - t), 64'(2));
        check("post_reset_len", 64'(tf - s0), 64'(100));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
